// File: rtl/lc4_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect
// and the decode handshake, seen from the fetch stage (master) or its environment (slave).
interface lc4_fetch_stage_if #(
  parameter int ADDR_W = 16,
  parameter int INSN_W = 20,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INSN_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic [INSN_W-1:0] dec_insn;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;
  logic [CNT_W-1:0]  inflight;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_insn, dec_pc, inflight,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_insn, dec_pc, inflight,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/lc4_fetch_stage.sv
// LC4 fetch stage: owns the PC, issues credit-limited fetches, pairs responses
// with their PCs and buffers them in a prefetch FIFO for the decoder.
//
// state    | meaning
// ST_RESET | first cycle after reset release, no requests yet
// ST_RUN   | normal fetching
module lc4_fetch_stage #(
  parameter int ADDR_W = 16,
  parameter int INSN_W = 20,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h8200)
) (
  input logic               clk,
  input logic               rst,
  lc4_fetch_stage_if.master fs
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_RESET, ST_RUN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;

  logic [INSN_W-1:0] insn_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pq_mem_q   [DEPTH];

  logic [CNT_W:0]    credit_use;
  logic              issue, resp, push, pop;

  assign credit_use   = {1'b0, count_q} + {1'b0, inflight_q};
  assign fs.imem_req  = (state_q == ST_RUN) & (credit_use < (CNT_W+1)'(DEPTH)) & ~fs.redirect_valid;
  assign fs.imem_addr = fetch_pc_q;
  assign fs.inflight  = inflight_q;

  assign issue = fs.imem_req & fs.imem_gnt;
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign resp  = fs.imem_rvalid & (inflight_q != '0);
  assign push  = resp & (drop_cnt_q == '0) & ~fs.redirect_valid;
  assign pop   = fs.dec_valid & fs.dec_ready & ~fs.redirect_valid;

  assign fs.dec_valid = (count_q != '0);
  assign fs.dec_insn  = fs.dec_valid ? insn_mem_q[rd_ptr_q] : '0;
  assign fs.dec_pc    = fs.dec_valid ? pc_mem_q[rd_ptr_q]   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(resp);

    if (fs.redirect_valid) begin
      // Everything still outstanding belongs to the old path.
      fetch_pc_d = fs.redirect_pc;
      drop_cnt_d = inflight_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        pq_wr_d    = pq_wr_q + PTR_W'(1);
      end
      if (resp) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        else                  pq_rd_d    = pq_rd_q + PTR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
    end else begin
      state_q    <= ST_RUN;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pq_mem_q[pq_wr_q] <= fetch_pc_q;
    if (push) begin
      insn_mem_q[wr_ptr_q] <= fs.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= pq_mem_q[pq_rd_q];
    end
  end
endmodule

// File: doc/lc4_fetch_stage.md
Name: lc4_fetch_stage

Overview:
- Instruction fetch stage directly upstream of the LC4 decoder: owns the PC, issues requests to instruction memory, and buffers returned 20-bit instructions in a small prefetch FIFO.
- Presents one instruction plus its PC per cycle to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/JSR/RTI resolution), flushes buffered work and discards stale in-flight responses.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width.
- INSN_W, 20, instruction width.
- DEPTH, 4, prefetch FIFO entries; also the maximum of buffered plus in-flight fetches (power of two, ≥2).
- RESET_PC, 16'h8200, PC value loaded at reset.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  ADDR_W  fetch address (current fetch PC).
- imem_gnt  input  1  memory accepts the request this cycle (req & gnt = issued).
- imem_rvalid  input  1  response valid; responses return in issue order, latency ≥1 cycle.
- imem_rdata  input  INSN_W  response instruction.
- redirect_valid  input  1  execute-stage redirect, single-cycle pulse.
- redirect_pc  input  ADDR_W  redirect target.
- dec_valid  output  1  dec_insn/dec_pc hold a valid instruction.
- dec_insn  output  INSN_W  instruction to decoder.
- dec_pc  output  ADDR_W  PC of dec_insn.
- dec_ready  input  1  decoder consumes (dec_valid & dec_ready = pop).
- inflight  output  $clog2(DEPTH)+1  current outstanding-request count (debug/verification).

Behaviour:
- Reset (async, any cycle): fetch_pc = RESET_PC, FIFO empty, inflight = 0, drop_cnt = 0, imem_req = 0, dec_valid = 0, dec_insn = 0, dec_pc = 0. imem_req first asserts the cycle after rst deasserts.
- Credit rule: imem_req = !rst_state & (fifo_count + inflight < DEPTH) & !redirect_valid. A response can never find the FIFO full.
- Issue: on req & gnt, fetch_pc += 1 (mod 2^ADDR_W; 16'hFFFF wraps to 0), inflight += 1, and the issued PC is pushed into a side PC queue (same depth) so each response is paired with its address.
- Response: on imem_rvalid, inflight -= 1. If drop_cnt > 0, the response is discarded and drop_cnt -= 1; otherwise {rdata, pc} is pushed into the FIFO.
  - Issue and response in the same cycle: inflight unchanged.
  - rvalid with inflight = 0 is a protocol error; the response is ignored (assertion in bench).
- Output: dec_valid = FIFO non-empty; dec_insn/dec_pc = FIFO head (registered storage, combinational read of head). Pop on dec_valid & dec_ready. Push and pop in the same cycle are legal at any occupancy, including full.
- Latency: request issued in cycle N, rvalid in cycle N+L → dec_valid in cycle N+L+1 (FIFO write, then visible).
- Redirect (redirect_valid = 1 in cycle N), taking priority over all else. At the edge ending cycle N:
  - FIFO and PC queue cleared.
  - fetch_pc = redirect_pc.
  - drop_cnt = inflight after accounting for any response arriving in cycle N (that response is itself discarded).
  - No request is issued in cycle N.
  - In cycle N+1, dec_valid = 0 and the first request to redirect_pc may issue.
  - A pop attempted in cycle N is ignored by the decoder contract: the redirect wins.
- Back-to-back redirects: each reloads fetch_pc; drop_cnt recomputed from current inflight, never lost.
- Stall: dec_ready = 0 holds the head stable (dec_insn/dec_pc unchanged) until popped. Fetch continues until the credit limit.
- Sustained throughput: with DEPTH ≥ L+1 and dec_ready = 1, one instruction per cycle.

Test Plan:
- Reset release, gnt = 1, fixed latency 1, dec_ready = 1 → requests at 8200, 8201, 8202…; dec_pc 8200 first valid 2 cycles after first issue; then one per cycle with no bubbles.
- dec_ready = 0 for 10 cycles, latency 2 → exactly DEPTH = 4 requests issued, imem_req drops; FIFO holds 8200–8203; head stays 8200. Release ready → 4 consecutive pops, fetch resumes at 8204.
- Redirect to 16'h0040 with 3 responses in flight → next 3 rvalids discarded (dec_valid stays 0); first dec_pc = 0040; inflight returns to 0 correctly.
- Redirect in the same cycle as an rvalid and a pop attempt → that response dropped, FIFO empty next cycle, imem_addr = target.
- Address wrap: redirect to 16'hFFFE → dec_pc sequence FFFE, FFFF, 0000, 0001.
- Async rst asserted mid-stream with responses pending → outputs zero immediately, not waiting for a clock edge. After release, fetch restarts at 8200; stale rvalids are not counted.
